// File: rtl/vga_timing_pkg.sv
// Shared timing types and mode presets for the VGA/DVI raster generator.
// vga_axis_t holds the four phase lengths of one axis (active, front porch,
// sync, back porch); vga_timing_t pairs a horizontal and a vertical axis.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
  } vga_timing_t;

  // Standard 640x480 @ 60 Hz (25.175 MHz pixel clock), 800x525 total.
  localparam vga_timing_t VGA_640X480_60 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48},
    v: '{active: 480, fp: 10, sync: 2,  bp: 33}
  };

  localparam int unsigned VGA_DEFAULT_CW = 11;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: a wrap counter over ACTIVE+FP+SYNC+BP positions plus the
// phase decode of the current count.
// Ports:
//   clk, resetn  - clock, async active-low reset
//   step         - advance the counter this cycle
//   count        - current position (registered)
//   wrap         - step taken while at the last position (combinational)
//   in_active    - count in [0, ACTIVE) (combinational)
//   in_sync      - count in [ACTIVE+FP, ACTIVE+FP+SYNC) (combinational)
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_640X480_60.h.active,
  parameter int unsigned FP     = VGA_640X480_60.h.fp,
  parameter int unsigned SYNC   = VGA_640X480_60.h.sync,
  parameter int unsigned BP     = VGA_640X480_60.h.bp,
  parameter int unsigned CW     = VGA_DEFAULT_CW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          in_active,
  output logic          in_sync
);

  localparam int unsigned      TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam longint unsigned  MAX_CNT = (64'd1 << CW) - 64'd1;

  // Reject degenerate or overflowing modes at elaboration.
  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_zero
    $error("vga_axis_cnt: ACTIVE/FP/SYNC/BP must all be non-zero");
  end
  if (CW == 0 || CW > 32) begin : g_bad_cw
    $error("vga_axis_cnt: CW must be in 1..32");
  end
  if ((64'(TOTAL) - 64'd1) > MAX_CNT) begin : g_bad_fit
    $error("vga_axis_cnt: total-1 does not fit in CW bits");
  end

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          at_last;

  // Next count: increment on step, wrap to zero after the last position.
  always_comb begin
    count_d = count_q;
    at_last = (count_q == LAST);
    if (step) begin
      count_d = at_last ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign wrap      = step && at_last;
  assign in_active = (count_q < ACT_END);
  assign in_sync   = (count_q >= SYNC_START) && (count_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator. Every output is registered
// and reflects the counter position sampled on the previous enabled cycle.
// Ports:
//   clk, resetn  - pixel-domain clock, async active-low reset
//   en           - pixel enable; nothing advances while low
//   hsync/vsync  - sync pulses, active level HS_POL/VS_POL
//   de           - display enable (both axes in their active region)
//   x, y         - pixel coordinate, updated only while de, else held
//   line_start   - one-cycle strobe for the first pixel of each line
//   frame_start  - one-cycle strobe for the first pixel of each frame
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640X480_60.h.active,
  parameter int unsigned H_FP     = VGA_640X480_60.h.fp,
  parameter int unsigned H_SYNC   = VGA_640X480_60.h.sync,
  parameter int unsigned H_BP     = VGA_640X480_60.h.bp,
  parameter int unsigned V_ACTIVE = VGA_640X480_60.v.active,
  parameter int unsigned V_FP     = VGA_640X480_60.v.fp,
  parameter int unsigned V_SYNC   = VGA_640X480_60.v.sync,
  parameter int unsigned V_BP     = VGA_640X480_60.v.bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = VGA_DEFAULT_CW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          h_active;
  logic          h_in_sync;
  logic          v_active;
  logic          v_in_sync;
  logic          v_wrap_unused;

  // Horizontal axis advances on every enabled pixel.
  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .step      (en),
    .count     (h_cnt),
    .wrap      (h_wrap),
    .in_active (h_active),
    .in_sync   (h_in_sync)
  );

  // Vertical axis advances once per completed line.
  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .step      (h_wrap),
    .count     (v_cnt),
    .wrap      (v_wrap_unused),
    .in_active (v_active),
    .in_sync   (v_in_sync)
  );

  logic          hsync_q,       hsync_d;
  logic          vsync_q,       vsync_d;
  logic          de_q,          de_d;
  logic [CW-1:0] x_q,           x_d;
  logic [CW-1:0] y_q,           y_d;
  logic          line_start_q,  line_start_d;
  logic          frame_start_q, frame_start_d;

  // Output decode from the pre-increment counters; levels hold and strobes
  // drop while en is low.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      de_d          = h_active && v_active;
      hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
      vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      if (h_active && v_active) begin
        x_d = h_cnt;
        y_d = v_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (package defaults, a small
// positive-polarity mode, the all-ones minimal mode, 800x600 positive
// polarity) driven by a shared en/resetn and compared every cycle against a
// raster model that works from a linear frame position.
module tb_vga_timing_gen;

  localparam int ND = 4;
  localparam int M_HA [ND] = '{640, 8, 1, 800};
  localparam int M_HF [ND] = '{16,  2, 1, 40};
  localparam int M_HS [ND] = '{96,  3, 1, 128};
  localparam int M_HB [ND] = '{48,  2, 1, 88};
  localparam int M_VA [ND] = '{480, 5, 1, 600};
  localparam int M_VF [ND] = '{10,  1, 1, 1};
  localparam int M_VS [ND] = '{2,   2, 1, 4};
  localparam int M_VB [ND] = '{33,  1, 1, 23};
  localparam int M_HP [ND] = '{0,   1, 0, 1};
  localparam int M_VP [ND] = '{0,   1, 0, 1};

  logic clk = 1'b0;
  logic resetn;
  logic en;

  always #5 clk = ~clk;

  logic        hs0, vs0, de0, ls0, fs0;
  logic [10:0] x0, y0;
  logic        hs1, vs1, de1, ls1, fs1;
  logic [4:0]  x1, y1;
  logic        hs2, vs2, de2, ls2, fs2;
  logic [2:0]  x2, y2;
  logic        hs3, vs3, de3, ls3, fs3;
  logic [10:0] x3, y3;

  vga_timing_gen u_dut0 (
    .clk(clk), .resetn(resetn), .en(en), .hsync(hs0), .vsync(vs0), .de(de0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .en(en), .hsync(hs1), .vsync(vs1), .de(de1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(3)
  ) u_dut2 (
    .clk(clk), .resetn(resetn), .en(en), .hsync(hs2), .vsync(vs2), .de(de2),
    .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) u_dut3 (
    .clk(clk), .resetn(resetn), .en(en), .hsync(hs3), .vsync(vs3), .de(de3),
    .x(x3), .y(y3), .line_start(ls3), .frame_start(fs3)
  );

  int o_hs [ND];
  int o_vs [ND];
  int o_de [ND];
  int o_ls [ND];
  int o_fs [ND];
  int o_x  [ND];
  int o_y  [ND];

  assign o_hs[0] = 32'(hs0);  assign o_hs[1] = 32'(hs1);
  assign o_hs[2] = 32'(hs2);  assign o_hs[3] = 32'(hs3);
  assign o_vs[0] = 32'(vs0);  assign o_vs[1] = 32'(vs1);
  assign o_vs[2] = 32'(vs2);  assign o_vs[3] = 32'(vs3);
  assign o_de[0] = 32'(de0);  assign o_de[1] = 32'(de1);
  assign o_de[2] = 32'(de2);  assign o_de[3] = 32'(de3);
  assign o_ls[0] = 32'(ls0);  assign o_ls[1] = 32'(ls1);
  assign o_ls[2] = 32'(ls2);  assign o_ls[3] = 32'(ls3);
  assign o_fs[0] = 32'(fs0);  assign o_fs[1] = 32'(fs1);
  assign o_fs[2] = 32'(fs2);  assign o_fs[3] = 32'(fs3);
  assign o_x[0]  = 32'(x0);   assign o_x[1]  = 32'(x1);
  assign o_x[2]  = 32'(x2);   assign o_x[3]  = 32'(x3);
  assign o_y[0]  = 32'(y0);   assign o_y[1]  = 32'(y1);
  assign o_y[2]  = 32'(y2);   assign o_y[3]  = 32'(y3);

  int n_checks;
  int n_pass;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pos is the linear index of the next pixel within the frame.
  int pos  [ND];
  int e_hs [ND];
  int e_vs [ND];
  int e_de [ND];
  int e_x  [ND];
  int e_y  [ND];
  int e_ls [ND];
  int e_fs [ND];

  int cyc;
  bit steady;
  int last_fs [ND];
  int ls_cnt  [ND];
  int n_period;
  int prev_ls [ND];

  function automatic int h_total(input int d);
    return M_HA[d] + M_HF[d] + M_HS[d] + M_HB[d];
  endfunction

  function automatic int v_total(input int d);
    return M_VA[d] + M_VF[d] + M_VS[d] + M_VB[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      pos[d]  = 0;
      e_hs[d] = 1 - M_HP[d];
      e_vs[d] = 1 - M_VP[d];
      e_de[d] = 0;
      e_x[d]  = 0;
      e_y[d]  = 0;
      e_ls[d] = 0;
      e_fs[d] = 0;
      prev_ls[d] = 0;
    end
  endtask

  task automatic model_step(input bit en_v);
    for (int d = 0; d < ND; d++) begin
      if (en_v) begin
        int h, v, hsb, vsb;
        h   = pos[d] % h_total(d);
        v   = pos[d] / h_total(d);
        hsb = M_HA[d] + M_HF[d];
        vsb = M_VA[d] + M_VF[d];
        e_de[d] = (h < M_HA[d] && v < M_VA[d]) ? 1 : 0;
        e_hs[d] = (h >= hsb && h < hsb + M_HS[d]) ? M_HP[d] : 1 - M_HP[d];
        e_vs[d] = (v >= vsb && v < vsb + M_VS[d]) ? M_VP[d] : 1 - M_VP[d];
        if (e_de[d] == 1) begin
          e_x[d] = h;
          e_y[d] = v;
        end
        e_ls[d] = (h == 0) ? 1 : 0;
        e_fs[d] = (pos[d] == 0) ? 1 : 0;
        pos[d]  = (pos[d] + 1) % (h_total(d) * v_total(d));
      end else begin
        e_ls[d] = 0;
        e_fs[d] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("d%0d_hsync", d), o_hs[d], e_hs[d]);
      check_eq($sformatf("d%0d_vsync", d), o_vs[d], e_vs[d]);
      check_eq($sformatf("d%0d_de", d),    o_de[d], e_de[d]);
      check_eq($sformatf("d%0d_x", d),     o_x[d],  e_x[d]);
      check_eq($sformatf("d%0d_y", d),     o_y[d],  e_y[d]);
      check_eq($sformatf("d%0d_line_start", d),  o_ls[d], e_ls[d]);
      check_eq($sformatf("d%0d_frame_start", d), o_fs[d], e_fs[d]);
    end
  endtask

  // Frame period / line count, only meaningful while en is held high.
  task automatic track_frames();
    for (int d = 1; d <= 2; d++) begin
      if (steady && o_ls[d] == 1) begin
        if (o_fs[d] == 1) begin
          if (last_fs[d] >= 0) begin
            check_eq($sformatf("d%0d_frame_period", d), cyc - last_fs[d],
                     h_total(d) * v_total(d));
            check_eq($sformatf("d%0d_lines_per_frame", d), ls_cnt[d], v_total(d));
            n_period++;
          end
          last_fs[d] = cyc;
          ls_cnt[d]  = 1;
        end else begin
          ls_cnt[d]++;
        end
      end
    end
  endtask

  task automatic step(input bit en_v);
    en = en_v;
    @(posedge clk);
    #1;
    cyc++;
    model_step(en_v);
    check_all();
    track_frames();
    for (int d = 0; d < ND; d++) begin
      if (o_ls[d] == 1) begin
        check_eq($sformatf("d%0d_strobe_single", d), prev_ls[d], 0);
      end
      prev_ls[d] = o_ls[d];
    end
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    n_period = 0;
    steady   = 1'b0;
    resetn   = 1'b0;
    en       = 1'b0;
    for (int d = 0; d < ND; d++) begin
      last_fs[d] = -1;
      ls_cnt[d]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all();
    resetn = 1'b1;

    // en held high: first pixel, two-plus lines of the default mode,
    // many frames of the small modes.
    steady = 1'b1;
    step(1'b1);
    check_eq("first_frame_start", o_fs[0], 1);
    check_eq("first_de", o_de[0], 1);
    check_eq("first_x", o_x[0], 0);
    check_eq("first_y", o_y[0], 0);
    repeat (2200) step(1'b1);
    check_eq("frame_periods_seen", (n_period >= 4) ? 1 : 0, 1);
    steady = 1'b0;

    // 1-of-4 enable duty.
    for (int i = 0; i < 1000; i++) begin
      step(1'b1);
      repeat (3) step(1'b0);
    end

    // Random enable with an asynchronous reset mid-run.
    for (int i = 0; i < 4000; i++) begin
      if (i == 1777) begin
        pulse_reset();
        step(1'b1);
        check_eq("restart_frame_start", o_fs[0], 1);
        check_eq("restart_x", o_x[0], 0);
      end
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
